// File: rtl/reset_sync_pkg.sv
// Shared constants for the reset synchronizer chain.
`timescale 1ns/1ps
package reset_sync_pkg;

  // Legal depth range of the synchronizing chain and its default depth.
  localparam int unsigned RST_SYNC_STAGES_DEF = 2;
  localparam int unsigned RST_SYNC_STAGES_MIN = 2;
  localparam int unsigned RST_SYNC_STAGES_MAX = 8;

endpackage : reset_sync_pkg

// File: rtl/reset_sync_if.sv
// Bundle carrying a synchronized active-low reset to its consumers.
`timescale 1ns/1ps
interface reset_sync_if;

  logic sync_rst;

  // The synchronizer drives the reset; consumers only observe it.
  modport master (output sync_rst);
  modport slave  (input  sync_rst);

endinterface : reset_sync_if

// File: rtl/reset_sync_sync_stage.sv
// One synchronizer stage: a D flip-flop with synchronous active-low clear.
`timescale 1ns/1ps
module sync_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Kept as a discrete register: no retiming, no shift-register packing.
  (* keep = "true", dont_touch = "true", async_reg = "true", shreg_extract = "no" *)
  logic q_q;
  logic q_d;

  // Next value is simply the upstream stage.
  always_comb begin
    q_d = d;
  end

  // Register with synchronous clear; no asynchronous set or clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : sync_stage

// File: rtl/reset_sync.sv
// Reset synchronizer: asserts SYNC_RST on the first edge sampling RST low,
// releases it NUM_STAGES edges after RST is sampled high continuously.
`timescale 1ns/1ps
module reset_sync
  import reset_sync_pkg::*;
#(
  parameter int unsigned NUM_STAGES = RST_SYNC_STAGES_DEF
) (
  input  logic CLK,
  input  logic RST,
  output logic SYNC_RST
);

  // Reject chain depths outside the supported range at elaboration.
  if ((NUM_STAGES < RST_SYNC_STAGES_MIN) || (NUM_STAGES > RST_SYNC_STAGES_MAX)) begin : g_bad_depth
    $error("reset_sync: NUM_STAGES=%0d outside %0d..%0d",
           NUM_STAGES, RST_SYNC_STAGES_MIN, RST_SYNC_STAGES_MAX);
  end

  logic [NUM_STAGES-1:0] chain;

  // Stage 0 loads a constant 1; each later stage follows its predecessor.
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      sync_stage u_stage (
        .clk   (CLK),
        .rst_n (RST),
        .d     (1'b1),
        .q     (chain[i])
      );
    end else begin : g_next
      sync_stage u_stage (
        .clk   (CLK),
        .rst_n (RST),
        .d     (chain[i-1]),
        .q     (chain[i])
      );
    end
  end

  // Output comes straight from the last register: glitch-free, no RST path.
  assign SYNC_RST = chain[NUM_STAGES-1];

endmodule : reset_sync

// File: tb/tb_reset_sync.sv
// Directed bench for reset_sync at chain depths 2, 3 and 4 sharing one RST.
`timescale 1ns/1ps
module tb_reset_sync;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  reset_sync_if if2 ();
  reset_sync_if if3 ();
  reset_sync_if if4 ();

  reset_sync #(.NUM_STAGES(2)) dut2 (.CLK(clk), .RST(rst), .SYNC_RST(if2.sync_rst));
  reset_sync #(.NUM_STAGES(3)) dut3 (.CLK(clk), .RST(rst), .SYNC_RST(if3.sync_rst));
  reset_sync #(.NUM_STAGES(4)) dut4 (.CLK(clk), .RST(rst), .SYNC_RST(if4.sync_rst));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;

    // Reset sampled low at the first edge: every output low.
    tick();
    chk("rst_n2", if2.sync_rst, 1'b0);
    chk("rst_n3", if3.sync_rst, 1'b0);
    chk("rst_n4", if4.sync_rst, 1'b0);

    // Release: depth N rises exactly at the N-th edge sampling RST=1.
    rst = 1'b1;
    tick();
    chk("rel_e1_n2", if2.sync_rst, 1'b0);
    chk("rel_e1_n3", if3.sync_rst, 1'b0);
    chk("rel_e1_n4", if4.sync_rst, 1'b0);
    tick();
    chk("rel_e2_n2", if2.sync_rst, 1'b1);
    chk("rel_e2_n3", if3.sync_rst, 1'b0);
    chk("rel_e2_n4", if4.sync_rst, 1'b0);
    tick();
    chk("rel_e3_n3", if3.sync_rst, 1'b1);
    chk("rel_e3_n4", if4.sync_rst, 1'b0);
    tick();
    chk("rel_e4_n4", if4.sync_rst, 1'b1);
    chk("rel_e4_n2", if2.sync_rst, 1'b1);
    tick();
    chk("hold_n2", if2.sync_rst, 1'b1);
    chk("hold_n3", if3.sync_rst, 1'b1);
    chk("hold_n4", if4.sync_rst, 1'b1);

    // Short low across one edge, raised 4.5 ns after the following falling edge.
    rst = 1'b0;
    tick();
    chk("pulse_assert_n2", if2.sync_rst, 1'b0);
    chk("pulse_assert_n4", if4.sync_rst, 1'b0);
    @(negedge clk);
    #4.5;
    rst = 1'b1;
    tick();
    chk("pulse_e1_n2", if2.sync_rst, 1'b0);
    tick();
    chk("pulse_e2_n2", if2.sync_rst, 1'b1);
    chk("pulse_e2_n3", if3.sync_rst, 1'b0);
    tick();
    chk("pulse_e3_n3", if3.sync_rst, 1'b1);
    chk("pulse_e3_n4", if4.sync_rst, 1'b0);
    tick();
    chk("pulse_e4_n4", if4.sync_rst, 1'b1);

    // 3 ns glitch between edges is never sampled and must be invisible.
    #2;
    rst = 1'b0;
    #1;
    chk("glitch_during_n3", if3.sync_rst, 1'b1);
    #2;
    rst = 1'b1;
    tick();
    chk("glitch_e1_n3", if3.sync_rst, 1'b1);
    chk("glitch_e1_n2", if2.sync_rst, 1'b1);
    tick();
    chk("glitch_e2_n3", if3.sync_rst, 1'b1);

    // Mid-release reset restarts the count from zero.
    rst = 1'b0;
    tick();
    chk("mid_assert_n3", if3.sync_rst, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_r1_e1_n3", if3.sync_rst, 1'b0);
    tick();
    chk("mid_r1_e2_n3", if3.sync_rst, 1'b0);
    chk("mid_r1_e2_n2", if2.sync_rst, 1'b1);
    rst = 1'b0;
    tick();
    chk("mid_reassert_n3", if3.sync_rst, 1'b0);
    chk("mid_reassert_n2", if2.sync_rst, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_r2_e1_n3", if3.sync_rst, 1'b0);
    tick();
    chk("mid_r2_e2_n3", if3.sync_rst, 1'b0);
    tick();
    chk("mid_r2_e3_n3", if3.sync_rst, 1'b1);
    chk("mid_r2_e3_n4", if4.sync_rst, 1'b0);
    tick();
    chk("mid_r2_e4_n4", if4.sync_rst, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reset_sync

// File: doc/reset_sync.md
RESET_SYNC -- requirements
Module: reset_sync

Interface
REQ-001 Parameter NUM_STAGES, default 2, meaning number of flip-flop stages in the synchronizing chain; legal range 2..8.
REQ-002 CLK  input  1  destination-domain clock; all state updates on its rising edge only.
REQ-003 RST  input  1  reset, synchronous, active-low; it is sampled only on the rising edge of CLK.
REQ-004 SYNC_RST  output  1  synchronized active-low reset for the CLK domain, driven directly from the last chain stage (registered, glitch-free).

Function
REQ-005 Internal chain: NUM_STAGES single-bit registers, stage[0] to stage[NUM_STAGES-1]; SYNC_RST = stage[NUM_STAGES-1].
REQ-006 On a rising CLK edge with RST=0, the block SHALL clear every stage to 0, so SYNC_RST=0 after that same edge.
REQ-007 On a rising CLK edge with RST=1, the block SHALL load stage[0] with 1 and stage[i] with stage[i-1] for i=1..NUM_STAGES-1.
REQ-008 Assertion latency: SYNC_RST SHALL go low at the first rising edge that samples RST=0, i.e. 1 cycle (0 cycles if RST is already low at that edge).
REQ-009 Deassertion latency: SYNC_RST SHALL go high at the NUM_STAGES-th consecutive rising edge that samples RST=1, and not before.
REQ-010 A RST low pulse that no rising edge samples SHALL have no effect.
REQ-011 A RST low sample during deassertion (reset mid-release) SHALL clear the whole chain and restart the NUM_STAGES count from zero.
REQ-012 While RST is held high, SYNC_RST SHALL stay 1 indefinitely once reached; the block holds no other state.
REQ-013 SYNC_RST SHALL change only on rising CLK edges, with no combinational path from RST to SYNC_RST.
REQ-014 A NUM_STAGES outside 2..8 SHALL cause an elaboration-time error.

Reset
REQ-015 The reset value of every stage and of SYNC_RST SHALL be 0, applied synchronously per REQ-006.
REQ-016 Power-up value before the first sampled edge is undefined; consumers rely only on behaviour after the first rising edge that samples RST=0.
REQ-017 No asynchronous set or clear SHALL exist on any chain register.

Structure
REQ-018 The default and limits for NUM_STAGES (2, min 2, max 8) SHALL be constants in the shared project package; no typedefs are needed.
REQ-019 One sub-module, sync_stage (a single D flip-flop with synchronous active-low clear), is natural and SHALL be instantiated NUM_STAGES times through a generate loop.
REQ-020 All chain registers SHALL carry the synthesis attributes that preserve them and prevent them from being retimed or shift-register-packed.

Verification
REQ-021 CLK period 10 ns, NUM_STAGES=2: drive RST=0 over one rising edge, then RST=1 -> SYNC_RST=0 after that edge, then 1 exactly at the 2nd rising edge that samples RST=1.
REQ-022 NUM_STAGES=4, same stimulus -> SYNC_RST rises at the 4th rising edge that samples RST=1; it stays 0 at edges 1-3.
REQ-023 NUM_STAGES=2 with SYNC_RST=1: drive RST=0 just after a rising edge and raise it again 4.5 ns after the next falling edge -> SYNC_RST=0 for the edge that sampled RST=0, then 1 again 2 edges later.
REQ-024 NUM_STAGES=3: a RST low pulse of 3 ns placed between two rising edges -> SYNC_RST stays 1 throughout.
REQ-025 NUM_STAGES=3, mid-release: RST=1 for 2 edges, RST=0 for 1 edge, then RST=1 -> SYNC_RST stays 0 until the 3rd edge after the second release.
REQ-026 Elaborate with NUM_STAGES=1 and with NUM_STAGES=9 -> each fails with an elaboration error.
